// File: rtl/ysyx_25020047_wb_ctrl.sv
// Multi-cycle commit sequencer: owns the PC and walks each instruction through
// fetch, execute, optional memory access and writeback with IFU/LSU handshakes.
module ysyx_25020047_wb_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_addr,
  input  logic        ifu_resp_valid,
  input  logic [31:0] ifu_inst,
  output logic [31:0] inst,
  input  logic [63:0] inst_type,
  input  logic [4:0]  rd,
  input  logic        ebreak,
  output logic [31:0] snpc,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  output logic        lsu_wen,
  input  logic        lsu_resp_valid,
  input  logic [31:0] lsu_rdata,
  output logic [31:0] memdata,
  input  logic [31:0] wbu_wdata,
  input  logic [31:0] wbu_dnpc,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic        commit,
  output logic        halted,
  output logic        err
);

  localparam logic [2:0] S_FREQ  = 3'd0;
  localparam logic [2:0] S_FWAIT = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MREQ  = 3'd3;
  localparam logic [2:0] S_MWAIT = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  logic [2:0]  state_r, state_nxt_s;
  logic [31:0] pc_r, inst_r, memdata_r, cnt_r;
  logic        ifu_req_valid_r, lsu_req_valid_r, lsu_wen_r;
  logic        load_cls_s, store_cls_s, branch_cls_s, reg_cls_s;
  logic        dnpc_ok_s, counting_s, tmo_s, ifu_acc_s, lsu_acc_s;

  assign load_cls_s   = inst_type[5] | inst_type[6];
  assign store_cls_s  = inst_type[7] | inst_type[8];
  assign branch_cls_s = inst_type[14] | inst_type[15];
  assign reg_cls_s    = (|inst_type) & ~load_cls_s & ~store_cls_s & ~branch_cls_s;
  assign dnpc_ok_s    = (wbu_dnpc[1:0] == 2'b00);
  assign ifu_acc_s    = ifu_req_valid_r & ifu_req_ready;
  assign lsu_acc_s    = lsu_req_valid_r & lsu_req_ready;
  // The first post-reset FREQ cycle has no request yet, so it does not count.
  assign counting_s   = ((state_r == S_FREQ) & ifu_req_valid_r) | (state_r == S_FWAIT) |
                        (state_r == S_MREQ) | (state_r == S_MWAIT);
  assign tmo_s        = counting_s & (cnt_r >= TMO_LAST);

  // Next-state selection; completion of a transaction beats the timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_FREQ: begin
        if (ifu_acc_s) state_nxt_s = S_FWAIT;
        else if (tmo_s) state_nxt_s = S_ERR;
        else state_nxt_s = S_FREQ;
      end
      S_FWAIT: begin
        if (ifu_resp_valid) state_nxt_s = S_EXEC;
        else if (tmo_s) state_nxt_s = S_ERR;
        else state_nxt_s = S_FWAIT;
      end
      S_EXEC: begin
        if (ebreak) state_nxt_s = S_HALT;
        else if (inst_type == 64'd0) state_nxt_s = S_ERR;
        else if (load_cls_s | store_cls_s) state_nxt_s = S_MREQ;
        else state_nxt_s = S_WB;
      end
      S_MREQ: begin
        if (lsu_acc_s) state_nxt_s = S_MWAIT;
        else if (tmo_s) state_nxt_s = S_ERR;
        else state_nxt_s = S_MREQ;
      end
      S_MWAIT: begin
        if (lsu_resp_valid) state_nxt_s = S_WB;
        else if (tmo_s) state_nxt_s = S_ERR;
        else state_nxt_s = S_MWAIT;
      end
      S_WB: begin
        if (dnpc_ok_s) state_nxt_s = S_FREQ;
        else state_nxt_s = S_ERR;
      end
      S_HALT:  state_nxt_s = S_HALT;
      S_ERR:   state_nxt_s = S_ERR;
      default: state_nxt_s = S_ERR;
    endcase
  end

  // State, architectural registers, transaction counter and request flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= S_FREQ;
      pc_r            <= RESET_PC;
      inst_r          <= 32'd0;
      memdata_r       <= 32'd0;
      cnt_r           <= 32'd0;
      ifu_req_valid_r <= 1'b0;
      lsu_req_valid_r <= 1'b0;
      lsu_wen_r       <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      ifu_req_valid_r <= (state_nxt_s == S_FREQ);
      lsu_req_valid_r <= (state_nxt_s == S_MREQ);
      lsu_wen_r       <= (state_nxt_s == S_MREQ) & store_cls_s;
      if ((state_nxt_s != state_r) && ((state_nxt_s == S_FREQ) || (state_nxt_s == S_MREQ)))
        cnt_r <= 32'd0;
      else if (counting_s)
        cnt_r <= cnt_r + 32'd1;
      else
        cnt_r <= cnt_r;
      if ((state_r == S_WB) && dnpc_ok_s) pc_r <= wbu_dnpc;
      else pc_r <= pc_r;
      if ((state_r == S_FWAIT) && ifu_resp_valid) inst_r <= ifu_inst;
      else inst_r <= inst_r;
      if ((state_r == S_MWAIT) && lsu_resp_valid && !store_cls_s) memdata_r <= lsu_rdata;
      else memdata_r <= memdata_r;
    end
  end

  assign ifu_req_valid = ifu_req_valid_r;
  assign ifu_addr      = pc_r;
  assign inst          = inst_r;
  assign snpc          = pc_r + 32'd4;
  assign lsu_req_valid = lsu_req_valid_r;
  assign lsu_wen       = lsu_wen_r;
  assign memdata       = memdata_r;
  assign commit        = (state_r == S_WB) & dnpc_ok_s;
  assign rf_wen        = commit & (reg_cls_s | load_cls_s) & (rd != 5'd0);
  assign rf_waddr      = rd;
  assign rf_wdata      = wbu_wdata;
  assign pc            = pc_r;
  assign halted        = (state_r == S_HALT);
  assign err           = (state_r == S_ERR);

endmodule

// File: tb/tb_ysyx_25020047_wb_ctrl.sv
// Randomized scoreboard bench for the commit sequencer: the driver plays IFU/IDU/LSU/WBU
// and queues the expected retirement; a monitor checks every commit pulse.
module tb_ysyx_25020047_wb_ctrl;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ifu_req_valid, ifu_req_ready = 1'b0, ifu_resp_valid = 1'b0;
  logic [31:0] ifu_addr, ifu_inst = 32'd0, inst;
  logic [63:0] inst_type = 64'd0;
  logic [4:0] rd = 5'd0, rf_waddr;
  logic ebreak = 1'b0;
  logic [31:0] snpc, memdata, wbu_wdata = 32'd0, wbu_dnpc = 32'd0, rf_wdata, pc;
  logic lsu_req_valid, lsu_req_ready = 1'b0, lsu_wen, lsu_resp_valid = 1'b0;
  logic [31:0] lsu_rdata = 32'd0;
  logic rf_wen, commit, halted, err;

  ysyx_25020047_wb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_inst(ifu_inst), .inst(inst),
    .inst_type(inst_type), .rd(rd), .ebreak(ebreak), .snpc(snpc),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .memdata(memdata),
    .wbu_wdata(wbu_wdata), .wbu_dnpc(wbu_dnpc), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .pc(pc), .commit(commit), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, inst, wdata, memdata;
    logic        rf_wen;
    logic [4:0]  waddr;
    int          lat, start;
  } rec_t;

  rec_t sb[$];
  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] model_pc = RST_PC, model_memdata = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: every commit must match the oldest queued retirement.
  always @(negedge clk) begin
    if (rst_n) begin
      if (commit) begin
        if (sb.size() == 0) check("unexpected_commit", 64'd1, 64'd0);
        else begin
          rec_t r;
          r = sb.pop_front();
          check("commit_pc", pc, r.pc);
          check("commit_inst", inst, r.inst);
          check("commit_rf_wen", rf_wen, r.rf_wen);
          if (r.rf_wen) begin
            check("commit_waddr", rf_waddr, r.waddr);
            check("commit_wdata", rf_wdata, r.wdata);
          end
          check("commit_memdata", memdata, r.memdata);
          check("commit_snpc", snpc, r.pc + 32'd4);
          check("latency", cyc - r.start + 1, r.lat);
        end
      end else if (rf_wen) check("rf_wen_without_commit", 64'd1, 64'd0);
    end
  end

  task automatic wait_ifu_req(output int start);
    int n = 0;
    while (!ifu_req_valid && n < 50) begin tick(); n++; end
    check("fetch_req_seen", ifu_req_valid, 1'b1);
    check("ifu_addr", ifu_addr, model_pc);
    start = cyc;
  endtask

  task automatic do_fetch(input int d1, input int d2, output logic [31:0] iw);
    repeat (d1) tick();
    ifu_req_ready = 1'b1; tick(); ifu_req_ready = 1'b0;
    repeat (d2) tick();
    iw = $urandom;
    ifu_inst = iw; ifu_resp_valid = 1'b1; tick(); ifu_resp_valid = 1'b0;
  endtask

  // One complete instruction; the expected retirement follows from the class rules.
  task automatic run_instr(input logic [63:0] ty, input logic [4:0] rdv, input logic [31:0] wd,
                           input logic [31:0] dn, input logic [31:0] rdat,
                           input int d1, input int d2, input int d3, input int d4);
    int start, n;
    logic [31:0] iw;
    logic is_ld, is_st, is_br;
    rec_t r;
    is_ld = (ty == 64'h20) || (ty == 64'h40);
    is_st = (ty == 64'h80) || (ty == 64'h100);
    is_br = (ty == 64'h4000) || (ty == 64'h8000);
    wait_ifu_req(start);
    inst_type = ty; rd = rdv; ebreak = 1'b0; wbu_wdata = wd; wbu_dnpc = dn;
    do_fetch(d1, d2, iw);
    if (is_ld) model_memdata = rdat;
    r.pc = model_pc; r.inst = iw; r.wdata = wd; r.memdata = model_memdata;
    r.rf_wen = !is_st && !is_br && (rdv != 5'd0);
    r.waddr = rdv; r.start = start;
    r.lat = 4 + d1 + d2 + ((is_ld || is_st) ? 2 + d3 + d4 : 0);
    sb.push_back(r);
    model_pc = dn;
    if (is_ld || is_st) begin
      n = 0;
      while (!lsu_req_valid && n < 50) begin tick(); n++; end
      check("lsu_req_seen", lsu_req_valid, 1'b1);
      check("lsu_wen", lsu_wen, is_st);
      repeat (d3) tick();
      check("lsu_req_held", lsu_req_valid, 1'b1);
      lsu_req_ready = 1'b1; tick(); lsu_req_ready = 1'b0;
      repeat (d4) tick();
      lsu_rdata = rdat; lsu_resp_valid = 1'b1; tick(); lsu_resp_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin tick(); n++; end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #1;
    check("reset_pc_async", pc, RST_PC);
    ifu_req_ready = 1'b0; ifu_resp_valid = 1'b0; lsu_req_ready = 1'b0; lsu_resp_valid = 1'b0;
    ebreak = 1'b0; inst_type = 64'd0;
    repeat (2) tick();
    rst_n = 1'b1;
    model_pc = RST_PC; model_memdata = 32'd0;
  endtask

  int ty_bits[11] = '{0, 1, 2, 5, 6, 7, 8, 14, 15, 20, 40};

  initial begin
    int start, n;
    logic [31:0] tmp, iw;
    // Reset values and first request timing
    repeat (2) tick();
    check("rst_ifu_valid", ifu_req_valid, 1'b0);
    check("rst_lsu_valid", lsu_req_valid, 1'b0);
    check("rst_flags", {rf_wen, commit, halted, err}, 4'b0000);
    check("rst_pc", pc, RST_PC);
    check("rst_inst", inst, 32'd0);
    check("rst_memdata", memdata, 32'd0);
    rst_n = 1'b1;
    check("ifu_valid_before_edge", ifu_req_valid, 1'b0);
    tick();
    check("ifu_valid_after_edge", ifu_req_valid, 1'b1);

    // Directed: addi, lw with slow ready, sw, beq, addi rd=0
    run_instr(64'h1, 5'd1, 32'd5, RST_PC + 32'd4, 32'd0, 0, 0, 0, 0);
    run_instr(64'h20, 5'd3, 32'h1234, RST_PC + 32'd8, 32'hDEADBEEF, 0, 0, 3, 0);
    run_instr(64'h80, 5'd4, 32'h55, RST_PC + 32'd12, 32'h0BAD0BAD, 0, 0, 0, 0);
    run_instr(64'h4000, 5'd5, 32'h66, 32'h8000_0100, 32'd0, 0, 0, 0, 0);
    run_instr(64'h1, 5'd0, 32'h77, 32'h8000_0104, 32'd0, 0, 0, 0, 0);

    // Randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      logic [63:0] ty;
      logic [31:0] dn;
      ty = 64'd1 << ty_bits[$urandom_range(0, 10)];
      tmp = $urandom;
      dn = ($urandom_range(0, 1) == 0) ? model_pc + 32'd4 : {tmp[31:2], 2'b00};
      run_instr(ty, 5'($urandom_range(0, 31)), $urandom, dn, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    drain();

    // ebreak halts without commit
    wait_ifu_req(start);
    inst_type = 64'h1; rd = 5'd2; ebreak = 1'b1;
    do_fetch(0, 0, iw);
    tick();
    check("halted", halted, 1'b1);
    repeat (3) tick();
    check("halt_no_requests", {ifu_req_valid, lsu_req_valid, commit}, 3'b000);
    do_reset();
    check("halt_cleared", halted, 1'b0);

    // inst_type == 0 raises err
    wait_ifu_req(start);
    inst_type = 64'd0; rd = 5'd1;
    do_fetch(0, 0, iw);
    tick();
    check("err_zero_type", err, 1'b1);
    do_reset();

    // Misaligned dnpc: no write, no commit, pc kept
    wait_ifu_req(start);
    inst_type = 64'h1; rd = 5'd7; wbu_dnpc = RST_PC + 32'd6;
    do_fetch(0, 0, iw);
    tick();
    check("misaligned_no_rf_wen", rf_wen, 1'b0);
    tick();
    check("err_misaligned", err, 1'b1);
    check("misaligned_pc_kept", pc, RST_PC);
    do_reset();

    // Fetch response never arrives
    wait_ifu_req(start);
    ifu_req_ready = 1'b1; tick(); ifu_req_ready = 1'b0;
    n = 0;
    while (!err && n < 400) begin tick(); n++; end
    check("timeout_err", err, 1'b1);
    check("timeout_cycles", cyc - start, 255);
    repeat (3) tick();
    check("err_no_requests", {ifu_req_valid, lsu_req_valid}, 2'b00);
    do_reset();

    // Reset during MWAIT with a late load response
    wait_ifu_req(start);
    inst_type = 64'h20; rd = 5'd9; wbu_dnpc = RST_PC + 32'd4;
    do_fetch(0, 0, iw);
    n = 0;
    while (!lsu_req_valid && n < 50) begin tick(); n++; end
    lsu_req_ready = 1'b1; tick(); lsu_req_ready = 1'b0;
    tick();
    rst_n = 1'b0; #1;
    check("midreset_pc", pc, RST_PC);
    check("midreset_lsu_valid", lsu_req_valid, 1'b0);
    lsu_rdata = 32'hDEADBEEF; lsu_resp_valid = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("late_resp_memdata", memdata, 32'd0);
    check("late_resp_fetching", ifu_req_valid, 1'b1);
    lsu_resp_valid = 1'b0;
    tick();
    check("late_resp_pc", pc, RST_PC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
